// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the PE operand feeder.
package pe_pkg;

  localparam int ELEM_W = 16;
  localparam int LANES  = 4;
  localparam int PACK_W = ELEM_W * LANES;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/pe_operand_feeder_if.sv
// Bundles for the feeder: the lane-write bus between the FSM and the
// lane packer, and the element/result stream bus seen by the environment.
interface pe_lane_if;
  import pe_pkg::*;

  logic              wr;
  logic              clear;
  logic [ELEM_W-1:0] a;
  logic [ELEM_W-1:0] b;
  logic [LANE_W-1:0] lane_cnt;
  logic [PACK_W-1:0] pack_a;
  logic [PACK_W-1:0] pack_b;

  modport master (output wr, clear, a, b, input lane_cnt, pack_a, pack_b);
  modport slave  (input wr, clear, a, b, output lane_cnt, pack_a, pack_b);
endinterface

interface pe_stream_if;
  import pe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_a;
  logic [ELEM_W-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;

  modport master (output in_valid, in_a, in_b, in_last, out_ready,
                  input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_a, in_b, in_last, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/pe_lane_packer.sv
// Collects up to four element pairs into packed PE operands. Lanes that
// are not written in a chunk stay zero because every chunk starts from a
// cleared state.
module pe_lane_packer
  import pe_pkg::*;
(
  input logic   CLK,
  input logic   reset_n,
  pe_lane_if.slave lane
);

  logic [LANE_W-1:0] lane_cnt_reg;
  wire  [LANES-1:0][ELEM_W-1:0] pack_a_w;
  wire  [LANES-1:0][ELEM_W-1:0] pack_b_w;

  // Lane pointer: advances per accepted pair, rewinds when the chunk is issued.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt_reg <= '0;
    end else if (lane.clear) begin
      lane_cnt_reg <= '0;
    end else if (lane.wr) begin
      lane_cnt_reg <= lane_cnt_reg + LANE_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gen_lane
      logic [ELEM_W-1:0] a_reg;
      logic [ELEM_W-1:0] b_reg;

      // One lane register pair: written when the pointer selects it.
      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (lane.clear) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (lane.wr && (lane_cnt_reg == LANE_W'(gi))) begin
          a_reg <= lane.a;
          b_reg <= lane.b;
        end
      end

      // Lane 0 sits in the most significant slice.
      assign pack_a_w[LANES-1-gi] = a_reg;
      assign pack_b_w[LANES-1-gi] = b_reg;
    end
  endgenerate

  assign lane.lane_cnt = lane_cnt_reg;
  assign lane.pack_a   = pack_a_w;
  assign lane.pack_b   = pack_b_w;

endmodule

// File: rtl/pe_operand_feeder.sv
// Feeds a fixed-latency 4-lane dot-product PE with chunks of an element
// stream and accumulates the partial results into one dot product.
module pe_operand_feeder
  import pe_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_a,
  input  logic [ELEM_W-1:0] in_b,
  input  logic              in_last,
  output logic              pe_en,
  output logic [PACK_W-1:0] pe_A,
  output logic [PACK_W-1:0] pe_B,
  input  logic [ELEM_W-1:0] pe_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data
);

  localparam int          WAIT_W    = 4;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg;
  logic [ELEM_W-1:0] acc_reg;
  logic [ELEM_W-1:0] out_data_reg;
  logic              last_reg;

  logic in_ready_c, pe_en_c, out_valid_c;
  logic lane_wr, lane_clear, sample;
  logic accept;

  pe_lane_if lane_bus ();

  pe_lane_packer u_packer (
    .CLK     (CLK),
    .reset_n (reset_n),
    .lane    (lane_bus.slave)
  );

  // Gated with reset so in_ready drops the moment reset asserts.
  assign in_ready  = in_ready_c & reset_n;
  assign pe_en     = pe_en_c;
  assign out_valid = out_valid_c;
  assign out_data  = out_data_reg;
  assign accept    = in_valid & in_ready;

  assign lane_bus.wr    = lane_wr;
  assign lane_bus.clear = lane_clear;
  assign lane_bus.a     = in_a;
  assign lane_bus.b     = in_b;
  assign pe_A           = lane_bus.pack_a;
  assign pe_B           = lane_bus.pack_b;

  // State register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_FILL;
    else          state_reg <= state_next;
  end

  // Next state and per-state controls.
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    pe_en_c     = 1'b0;
    out_valid_c = 1'b0;
    lane_wr     = 1'b0;
    lane_clear  = 1'b0;
    sample      = 1'b0;
    unique case (state_reg)
      ST_FILL: begin
        in_ready_c = 1'b1;
        if (accept) begin
          lane_wr = 1'b1;
          if (in_last || (lane_bus.lane_cnt == LANE_W'(LANES - 1)))
            state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        pe_en_c = 1'b1;
        if (wait_reg == WAIT_LAST) begin
          sample     = 1'b1;
          lane_clear = 1'b1;
          state_next = last_reg ? ST_RESULT : ST_FILL;
        end
      end
      ST_RESULT: begin
        out_valid_c = 1'b1;
        if (out_ready) state_next = ST_FILL;
      end
      default: state_next = ST_FILL;
    endcase
  end

  // PE wait counter: counts cycles the operands have been held in ISSUE.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                 wait_reg <= '0;
    else if (state_reg != ST_ISSUE) wait_reg <= '0;
    else if (wait_reg == WAIT_LAST) wait_reg <= '0;
    else                          wait_reg <= wait_reg + WAIT_W'(1);
  end

  // Remembers that the chunk being issued closes the vector.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                  last_reg <= 1'b0;
    else if (sample)               last_reg <= 1'b0;
    else if (accept && in_last)    last_reg <= 1'b1;
  end

  // Accumulator and result register; the sum wraps modulo 2^16.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg      <= '0;
      out_data_reg <= '0;
    end else begin
      if (sample) begin
        acc_reg <= acc_reg + pe_c;
        if (last_reg) out_data_reg <= acc_reg + pe_c;
      end else if ((state_reg == ST_RESULT) && out_ready) begin
        acc_reg <= '0;
      end
    end
  end

endmodule
